// File: rtl/wb_bridge_pkg.sv
// Shared types and constants for the RV32I data-port to Wishbone bridge.
// Holds the bridge FSM encoding, the error read pattern and the default timeout.
package wb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] WB_ERR_DATA = 32'hDEAD_BEEF;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/rv_wb_master_bridge_timeout.sv
// Bus-cycle watchdog for the Wishbone bridge (used only with WB_TIMEOUT_EN).
// expired pulses in the LIMIT-th consecutive ticking cycle after a clear.
module wb_timeout_counter
    import wb_bridge_pkg::*;
#(
    parameter int unsigned LIMIT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int unsigned W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: hold at zero while cleared, otherwise count silent cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = tick && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/rv_wb_master_bridge.sv
// RV32I data-memory port to Wishbone B4 classic master, one transfer at a time.
// Optional bus watchdog is compiled in when WB_TIMEOUT_EN is defined.
module rv_wb_master_bridge
    import wb_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_req,
    input  logic                    mem_we,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_be,
    output logic                    mem_ready,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    output logic                    bus_err_o
);

    localparam int unsigned SW = DATA_WIDTH / 8;

    state_e                state_q, state_d;
    logic                  cyc_q, cyc_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic                  timeout;

`ifdef WB_TIMEOUT_EN
    logic in_bus;
    logic to_tick;

    assign in_bus  = (state_q == BUS);
    assign to_tick = in_bus && !wb_ack_i && !wb_err_i;

    wb_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_bus),
        .tick   (to_tick),
        .expired(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // Next-state and registered-output logic for IDLE -> BUS -> DONE.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (mem_req) begin
                    we_d    = mem_we;
                    adr_d   = mem_addr;
                    dat_d   = mem_wdata;
                    sel_d   = mem_be;
                    cyc_d   = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                // A real err beats ack; the watchdog only acts on silence.
                if (wb_err_i || (timeout && !wb_ack_i)) begin
                    cyc_d   = 1'b0;
                    rdata_d = DATA_WIDTH'(WB_ERR_DATA);
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = DONE;
                end else if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    rdata_d = we_q ? '0 : wb_dat_i;
                    ready_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;
    assign bus_err_o = err_q;

endmodule

// File: tb/tb_rv_wb_master_bridge.sv
// Scoreboard bench for rv_wb_master_bridge; bench-side slave and core driver.
// Define WB_TIMEOUT_EN for both bench and RTL to cover the watchdog abort.
module tb_rv_wb_master_bridge;

    localparam int TO = 4;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_be = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        bus_err_o;

    int   total = 0;
    int   bad = 0;
    int   n_cyc = 0;
    int   exp_cyc = 0;
    logic exp_err = 1'b0;
    logic cyc_prev = 1'b0;
    logic rdy_prev = 1'b0;
    exp_t sb[$];

    rv_wb_master_bridge #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be   (mem_be),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Completion monitor: pop the scoreboard on every mem_ready pulse.
    always @(negedge clk) begin
        if (rst) begin
            cyc_prev = 1'b0;
            rdy_prev = 1'b0;
        end else begin
            chk("cyc_eq_stb", 96'(wb_cyc_o), 96'(wb_stb_o));
            if (wb_cyc_o && !cyc_prev) n_cyc++;
            if (mem_ready) begin
                chk("ready_1cyc", 96'(rdy_prev), 96'(0));
                if (sb.size() == 0) begin
                    chk("sb_empty", 96'(1), 96'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rdata", 96'(mem_rdata), 96'(e.rdata));
                    chk("bus_err", 96'(bus_err_o), 96'(e.err));
                end
            end
            cyc_prev = wb_cyc_o;
            rdy_prev = mem_ready;
        end
    end

    // One core access against a slave answering after 'waits' silent cycles.
    task automatic access(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int waits, input logic [31:0] rd,
                          input logic ack, input logic err,
                          input int exp_lat, input bit keep_req);
        exp_t e;
        logic [68:0] f;
        int n;
        if (err || !ack) begin
            e.rdata = ERRD;
            exp_err = 1'b1;
        end else begin
            e.rdata = we ? 32'h0 : rd;
        end
        e.err = exp_err;
        sb.push_back(e);
        exp_cyc++;
        f = {we, addr, wdata, be};
        mem_req = 1'b1;
        mem_we = we;
        mem_addr = addr;
        mem_wdata = wdata;
        mem_be = be;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wb_cyc_o && n < 8);
        chk("req_lat", 96'(n), 96'(exp_lat));
        chk("fields", 96'({wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o}), 96'(f));
        mem_we = ~we;
        mem_addr = ~addr;
        for (int i = 0; i < waits; i++) begin
            @(posedge clk);
            #1;
            chk("cyc_hold", 96'(wb_cyc_o), 96'(1));
            chk("stable", 96'({wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o}),
                96'(f));
        end
        wb_ack_i = ack;
        wb_err_i = err;
        wb_dat_i = rd;
        @(posedge clk);
        #1;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        chk("ready_lat", 96'(mem_ready), 96'(1));
        chk("cyc_drop", 96'(wb_cyc_o), 96'(0));
        mem_we = we;
        mem_addr = addr;
        if (!keep_req) mem_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", 96'({mem_ready, mem_rdata, wb_cyc_o, wb_stb_o,
                             wb_we_o, wb_adr_o, bus_err_o}), 96'(0));
        rst = 1'b0;

        access(1'b0, 32'h0000_1004, 32'h0, 4'b1111, 0, 32'h1234_5678,
               1'b1, 1'b0, 1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("ready_low", 96'(mem_ready), 96'(0));

        access(1'b1, 32'h0000_2000, 32'h0000_00AB, 4'b0001, 3,
               32'h5555_AAAA, 1'b1, 1'b0, 1, 1'b0);
        @(posedge clk);
        #1;

        access(1'b0, 32'h0000_3000, 32'h0, 4'b1111, 1, 32'hCAFE_0001,
               1'b1, 1'b1, 1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", 96'(bus_err_o), 96'(1));
        chk("rdata_hold", 96'(mem_rdata), 96'(ERRD));

        access(1'b0, 32'h0000_3004, 32'h0, 4'b1100, 2, 32'h0BAD_F00D,
               1'b1, 1'b0, 1, 1'b0);
        @(posedge clk);
        #1;

        mem_req = 1'b1;
        mem_we = 1'b0;
        mem_addr = 32'h0000_4000;
        mem_be = 4'b1111;
        @(posedge clk);
        #1;
        exp_cyc++;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async", 96'({mem_ready, mem_rdata, wb_cyc_o, wb_stb_o,
                              wb_we_o, wb_adr_o, wb_sel_o, bus_err_o}),
            96'(0));
        mem_req = 1'b0;
        sb.delete();
        exp_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        access(1'b0, 32'h0000_4008, 32'h0, 4'b1111, 0, 32'h7777_1111,
               1'b1, 1'b0, 1, 1'b0);
        @(posedge clk);
        #1;

        access(1'b0, 32'h0000_0010, 32'h0, 4'b1111, 0, 32'h0000_0010,
               1'b1, 1'b0, 1, 1'b1);
        access(1'b0, 32'h0000_0014, 32'h0, 4'b1111, 1, 32'h0000_0014,
               1'b1, 1'b0, 2, 1'b0);
        repeat (3) @(posedge clk);
        #1;

`ifdef WB_TIMEOUT_EN
        access(1'b0, 32'h0000_5000, 32'h0, 4'b1111, TO - 1, 32'h0,
               1'b0, 1'b0, 1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
`endif

        chk("wb_cycles", 96'(n_cyc), 96'(exp_cyc));
        chk("sb_drained", 96'(sb.size()), 96'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_wb_master_bridge.md
Name: rv_wb_master_bridge

Overview:
- Converts the RV32I core's single-cycle data-memory request port (mem_req/mem_we/mem_addr/mem_wdata/mem_be in, mem_ready/mem_rdata out) into Wishbone B4 classic master cycles toward the NoC network interface.
- Sits directly downstream of the core's LSU outputs and holds the core stalled via mem_ready until the bus transfer completes.
- One transfer in flight at a time; no pipelining.

Parameters:
- ADDR_WIDTH, 32, width of mem_addr and wb_adr_o.
- DATA_WIDTH, 32, width of the data paths; wb_sel_o is DATA_WIDTH/8 bits wide.
- TIMEOUT_CYCLES, 255, maximum wait for ack/err before abort. Used only when WB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  in  1  core request level, held until mem_ready.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  ADDR_WIDTH  byte address.
- mem_wdata  in  DATA_WIDTH  lane-aligned store data.
- mem_be  in  DATA_WIDTH/8  byte enables.
- mem_ready  out  1  one-cycle completion pulse to the core.
- mem_rdata  out  DATA_WIDTH  load data, valid when mem_ready=1.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  Wishbone write enable.
- wb_adr_o  out  ADDR_WIDTH  Wishbone address.
- wb_dat_o  out  DATA_WIDTH  Wishbone write data.
- wb_sel_o  out  DATA_WIDTH/8  Wishbone byte select.
- wb_dat_i  in  DATA_WIDTH  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error.
- bus_err_o  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset values: every output and all state is 0; FSM is in IDLE. Reset is asynchronous: asserting rst mid-transfer drops wb_cyc_o and wb_stb_o immediately, with no cycle termination.
- All outputs are registered.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - If mem_req=1 at a clock edge: capture mem_addr, mem_we, mem_wdata and mem_be into wb_adr_o, wb_we_o, wb_dat_o and wb_sel_o; set wb_cyc_o=wb_stb_o=1; go to BUS.
  - Otherwise stay in IDLE.
- BUS:
  - Core-side inputs are ignored; the captured request stays stable.
  - At the edge where wb_ack_i|wb_err_i=1: clear wb_cyc_o and wb_stb_o; go to DONE.
  - If wb_ack_i=1 and wb_err_i=0 on a load: mem_rdata <= wb_dat_i.
  - If wb_err_i=1: mem_rdata <= 32'hDEAD_BEEF and bus_err_o <= 1. Error takes priority when ack and err are both high.
  - On a store, mem_rdata <= 0.
  - wb_ack_i and wb_err_i are ignored outside BUS.
- DONE:
  - mem_ready=1 for exactly this cycle; next state is IDLE unconditionally.
  - The core advances its PC at this edge, so the same request is never reissued.
- mem_rdata holds its value until the next capture.
- Latency: request seen at edge N -> cyc/stb high during cycle N+1. With a zero-wait slave (ack in cycle N+1), mem_ready is high in cycle N+2. Back-to-back accesses therefore take 3 cycles each minimum, and wait states add 1:1.
- wb_cyc_o and wb_stb_o are always equal (classic, non-pipelined, no bursts). wb_we_o, wb_adr_o, wb_dat_o and wb_sel_o change only when leaving IDLE.
- If mem_req drops while in BUS (illegal core behaviour), the transfer still completes and mem_ready still pulses.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUS and increments every BUS cycle without ack/err.
  - When the counter reaches TIMEOUT_CYCLES with no ack/err, it is treated as wb_err_i: cyc/stb drop, mem_rdata=32'hDEAD_BEEF, bus_err_o=1, go to DONE.
  - A real ack or err in the same cycle as the timeout wins over the timeout.
- Undefined: no counter; BUS waits indefinitely.

Decomposition:
- Package wb_bridge_pkg holds:
  - state enum (IDLE=2'd0, BUS=2'd1, DONE=2'd2);
  - WB_ERR_DATA=32'hDEAD_BEEF;
  - DEFAULT_TIMEOUT=255.
- One sub-module: wb_timeout_counter (clk, rst, clear, tick, expired, parameter LIMIT), instantiated only under WB_TIMEOUT_EN.

Test Plan:
- Load, zero-wait slave: mem_req=1, we=0, addr=0x0000_1004; slave acks in the first BUS cycle with dat=0x1234_5678 -> wb_adr_o=0x1004, wb_sel_o=mem_be; mem_ready pulses 1 cycle, 2 cycles after the request edge, with mem_rdata=0x1234_5678.
- Store, 3 wait states: we=1, addr=0x2000, wdata=0x0000_00AB, be=4'b0001; ack after 3 cycles -> wb_we_o=1, wb_dat_o=0xAB and wb_sel_o=0001 stable throughout; mem_ready occurs 5 cycles after the request edge.
- Error: slave asserts err together with ack on a load -> mem_rdata=0xDEAD_BEEF and bus_err_o=1, held after the transfer, cleared only by rst.
- Reset mid-transfer: assert rst during the second BUS cycle -> cyc/stb go 0 asynchronously and all outputs 0; after release the FSM is in IDLE and a new request completes normally.
- Back-to-back: continuous mem_req with new addresses 0x10 and 0x14 issued after each mem_ready -> exactly two Wishbone cycles, no duplicate cycle, cyc low for at least 1 cycle between them.
- WB_TIMEOUT_EN with TIMEOUT_CYCLES=4: slave never responds -> abort after 4 BUS cycles; mem_ready pulses with mem_rdata=0xDEAD_BEEF and bus_err_o=1.
